// File: rtl/param_dcache.sv
// param_dcache: set-associative write-back data cache with tree-PLRU replacement,
// burst refill/writeback and an uncached single-beat bypass path.
package param_dcache_pkg;
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;
    typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module param_dcache
    import param_dcache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       d_uncached,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);
    localparam int OB = $clog2(LINE_WORDS * 4);
    localparam int IB = $clog2(SETS);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int TW = 32 - IB - OB;
    localparam int LV = $clog2(WAYS);
    localparam int WW = (LV > 0) ? LV : 1;
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, FILLDONE, UNCACHED} state_t;

    state_t state, state_n;
    logic [31:0] addr, wdata;
    msize_t size;
    logic [3:0] strobe;
    logic [31:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [TW-1:0] tag_mem [WAYS][SETS];
    logic [WAYS-1:0] valid_mem [SETS];
    logic [WAYS-1:0] dirty_mem [SETS];
    logic [PW-1:0] plru [SETS];
    logic [WW-1:0] victim, hit_way, pick_way, acc_way;
    logic [WB-1:0] cnt;
    logic hit;
    logic [31:0] line_word, merged;
    logic [TW-1:0] tag;
    logic [IB-1:0] idx;
    logic [WB-1:0] word;

    // Heap-ordered tree: node n has children 2n and 2n+1; bit 1 points right.
    function automatic logic [WW-1:0] plru_victim(input logic [PW-1:0] b);
        int n;
        n = 1;
        for (int l = 0; l < LV; l++) n = 2 * n + int'(b[n-1]);
        return WW'(n - WAYS);
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] b, input logic [WW-1:0] w);
        logic [PW-1:0] r;
        int n;
        r = b;
        n = 1;
        for (int l = 0; l < LV; l++) begin
            r[n-1] = ~w[LV-1-l];
            n = 2 * n + int'(w[LV-1-l]);
        end
        return r;
    endfunction

    assign tag  = addr[31 -: TW];
    assign idx  = addr[OB +: IB];
    assign word = addr[2 +: WB];
    assign acc_way   = (state == LOOKUP) ? hit_way : victim;
    assign line_word = data_mem[acc_way][idx][word];

    // Descending scan so the lowest-index invalid way wins over PLRU.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        pick_way = plru_victim(plru[idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && tag_mem[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_mem[idx][w]) pick_way = WW'(w);
        end
    end

    always_comb begin
        merged = line_word;
        for (int b = 0; b < 4; b++) if (strobe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end

    always_comb begin
        state_n = state;
        dresp = '0;
        creq = '0;
        dresp.addr_ok = resetn && state == IDLE && dreq.valid;
        case (state)
            IDLE: if (dreq.valid) state_n = d_uncached ? UNCACHED : LOOKUP;
            LOOKUP: begin
                dresp.data_ok = hit;
                dresp.data = hit ? line_word : 32'h0;
                state_n = hit ? IDLE : (dirty_mem[idx][pick_way] ? WRITEBACK : REFILL);
            end
            WRITEBACK: begin
                creq.valid = 1'b1;
                creq.is_write = 1'b1;
                creq.size = MSIZE4;
                creq.strobe = 4'b1111;
                creq.len = mlen_t'(4'(LINE_WORDS - 1));
                creq.addr = {tag_mem[victim][idx], idx, {OB{1'b0}}};
                creq.data = data_mem[victim][idx][cnt];
                if (cresp.ready && cresp.last) state_n = REFILL;
            end
            REFILL: begin
                creq.valid = 1'b1;
                creq.size = MSIZE4;
                creq.len = mlen_t'(4'(LINE_WORDS - 1));
                creq.addr = {tag, idx, {OB{1'b0}}};
                if (cresp.ready && cresp.last) state_n = FILLDONE;
            end
            FILLDONE: begin
                dresp.data_ok = 1'b1;
                dresp.data = line_word;
                state_n = IDLE;
            end
            UNCACHED: begin
                creq.valid = 1'b1;
                creq.is_write = |strobe;
                creq.size = size;
                creq.addr = addr;
                creq.strobe = strobe;
                creq.data = wdata;
                creq.len = MLEN1;
                dresp.data_ok = cresp.ready && cresp.last;
                dresp.data = (cresp.ready && cresp.last) ? cresp.data : 32'h0;
                if (cresp.ready && cresp.last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            victim <= '0;
            addr <= '0;
            wdata <= '0;
            size <= MSIZE1;
            strobe <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                plru[s] <= '0;
            end
        end else begin
            state <= state_n;
            if (state == IDLE && dreq.valid) begin
                addr <= dreq.addr;
                wdata <= dreq.data;
                size <= dreq.size;
                strobe <= dreq.strobe;
            end
            if (state == LOOKUP) victim <= pick_way;
            if ((state == WRITEBACK || state == REFILL) && cresp.ready)
                cnt <= cresp.last ? '0 : cnt + 1'b1;
            if (state == LOOKUP && hit) begin
                plru[idx] <= plru_touch(plru[idx], hit_way);
                if (|strobe) dirty_mem[idx][hit_way] <= 1'b1;
            end
            if (state == FILLDONE) begin
                valid_mem[idx][victim] <= 1'b1;
                dirty_mem[idx][victim] <= |strobe;
                plru[idx] <= plru_touch(plru[idx], victim);
            end
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (state == REFILL && cresp.ready) data_mem[victim][idx][cnt] <= cresp.data;
        if (state == FILLDONE) tag_mem[victim][idx] <= tag;
        if (((state == LOOKUP && hit) || state == FILLDONE) && |strobe)
            data_mem[acc_way][idx][word] <= merged;
    end
endmodule

// File: tb/tb_param_dcache.sv
// tb_param_dcache: directed scoreboard bench for param_dcache with a memory-model bus slave.
module tb_param_dcache;
    import param_dcache_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        mlen_t       len;
        msize_t      size;
        logic [3:0]  strobe;
    } burst_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic d_uncached = 1'b0;
    dbus_req_t dreq = '0;
    dbus_resp_t dresp;
    cbus_req_t creq;
    cbus_resp_t cresp = '0;

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    int hold = 0;
    int beat = 0;
    logic [31:0] exp_q[$];
    burst_t bus_q[$];
    logic [31:0] mem [logic [31:0]];
    cbus_req_t snap;
    bit pend = 0;
    logic [31:0] sa, sold;
    burst_t sb;

    always #5 clk = ~clk;

    param_dcache #(.WAYS(4), .SETS(16), .LINE_WORDS(4)) dut (
        .clk(clk),
        .resetn(resetn),
        .d_uncached(d_uncached),
        .dreq(dreq),
        .dresp(dresp),
        .creq(creq),
        .cresp(cresp)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hC000_0000 | a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus slave: answers creq from the memory model, optionally stalling the first beat.
    always @(negedge clk) begin
        if (pend && creq.valid) begin
            tests++;
            if (creq !== snap) begin
                fails++;
                $display("FAIL creq stable: got %h, expected %h", creq, snap);
            end
        end
        if (!resetn) beat = 0;
        else if (cresp.ready) beat = cresp.last ? 0 : beat + 1;
        cresp = '0;
        if (creq.valid) begin
            if (hold > 0) hold--;
            else begin
                sa = creq.addr + 32'(beat) * 32'd4;
                cresp.ready = 1'b1;
                cresp.last = (beat == int'(creq.len));
                if (beat == 0) begin
                    sb.addr = creq.addr;
                    sb.wr = creq.is_write;
                    sb.len = creq.len;
                    sb.size = creq.size;
                    sb.strobe = creq.strobe;
                    bus_q.push_back(sb);
                end
                if (creq.is_write) begin
                    sold = rd(sa);
                    for (int b = 0; b < 4; b++) if (creq.strobe[b]) sold[8*b +: 8] = creq.data[8*b +: 8];
                    mem[sa] = sold;
                end else cresp.data = rd(sa);
            end
        end
        pend = creq.valid && !cresp.ready;
        snap = creq;
    end

    // Monitor: sampled after the slave has settled cresp for this cycle.
    always @(negedge clk) begin
        #2;
        if (dresp.addr_ok) accepts++;
        if (creq.valid) check("addr_ok while busy", 32'(dresp.addr_ok), 32'h0);
        if (dresp.data_ok) begin
            if (exp_q.size() == 0) check("spurious data_ok", 32'(dresp.data_ok), 32'h0);
            else check("dresp.data", dresp.data, exp_q.pop_front());
        end
    end

    task automatic issue(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                         input bit unc, input msize_t sz, input bit push, input logic [31:0] e);
        int n;
        n = 0;
        dreq.valid = 1'b1;
        dreq.addr = a;
        dreq.strobe = st;
        dreq.data = d;
        dreq.size = sz;
        d_uncached = unc;
        if (push) exp_q.push_back(e);
        #1;
        while (!dresp.addr_ok && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept", 32'(dresp.addr_ok), 32'h1);
        @(posedge clk);
        #1;
        dreq.valid = 1'b0;
        d_uncached = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("completion pending", 32'(exp_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_burst(input string nm, input logic [31:0] a, input bit wr, input mlen_t ln,
                             input msize_t sz, input logic [3:0] st);
        burst_t b;
        if (bus_q.size() == 0) begin
            check({nm, " present"}, 32'(bus_q.size()), 32'h1);
            return;
        end
        b = bus_q.pop_front();
        check({nm, " addr"}, b.addr, a);
        check({nm, " is_write"}, 32'(b.wr), 32'(wr));
        check({nm, " len"}, 32'(b.len), 32'(ln));
        check({nm, " size"}, 32'(b.size), 32'(sz));
        check({nm, " strobe"}, 32'(b.strobe), 32'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, n;
        mem[32'h1000] = 32'hA0;
        mem[32'h1004] = 32'hA1;
        mem[32'h1008] = 32'hA2;
        mem[32'h100C] = 32'hA3;
        dreq.valid = 1'b1;
        dreq.addr = 32'h1008;
        repeat (2) @(posedge clk);
        #1;
        check("reset addr_ok", 32'(dresp.addr_ok), 32'h0);
        check("reset data_ok", 32'(dresp.data_ok), 32'h0);
        check("reset data", dresp.data, 32'h0);
        check("reset creq.valid", 32'(creq.valid), 32'h0);
        dreq = '0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // cold miss then hit
        issue(32'h1008, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hA2);
        wait_done();
        chk_burst("cold refill", 32'h1000, 0, MLEN4, MSIZE4, 4'h0);
        check("cold extra bursts", 32'(bus_q.size()), 32'h0);
        issue(32'h1008, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hA2);
        check("read hit latency", 32'(dresp.data_ok), 32'h1);
        wait_done();
        check("read hit bus idle", 32'(bus_q.size()), 32'h0);

        // write hit merges low half, returns old word
        issue(32'h1004, 4'b0011, 32'h1234_5678, 0, MSIZE4, 1, 32'hA1);
        check("write hit latency", 32'(dresp.data_ok), 32'h1);
        wait_done();
        issue(32'h1004, 4'h0, 32'h0, 0, MSIZE4, 1, 32'h0000_5678);
        wait_done();
        check("write hit bus idle", 32'(bus_q.size()), 32'h0);

        // fill remaining ways of set 0, then evict way 0 (dirty)
        issue(32'h0104, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_0104);
        wait_done();
        chk_burst("fill way1", 32'h0100, 0, MLEN4, MSIZE4, 4'h0);
        issue(32'h0208, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_0208);
        wait_done();
        chk_burst("fill way2", 32'h0200, 0, MLEN4, MSIZE4, 4'h0);
        issue(32'h030C, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_030C);
        wait_done();
        chk_burst("fill way3", 32'h0300, 0, MLEN4, MSIZE4, 4'h0);
        issue(32'h0500, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_0500);
        wait_done();
        chk_burst("victim writeback", 32'h1000, 1, MLEN4, MSIZE4, 4'hF);
        chk_burst("refill after wb", 32'h0500, 0, MLEN4, MSIZE4, 4'h0);
        check("wb word0", rd(32'h1000), 32'hA0);
        check("wb word1", rd(32'h1004), 32'h0000_5678);
        check("wb word3", rd(32'h100C), 32'hA3);
        issue(32'h1004, 4'h0, 32'h0, 0, MSIZE4, 1, 32'h0000_5678);
        wait_done();
        chk_burst("clean victim refill", 32'h1000, 0, MLEN4, MSIZE4, 4'h0);
        check("clean victim no wb", 32'(bus_q.size()), 32'h0);

        // uncached write with a stalled bus, then uncached read
        hold = 5;
        issue(32'hBFD0_0000, 4'b0001, 32'h0000_00EE, 1, MSIZE1, 1, 32'h0);
        wait_done();
        chk_burst("uncached write", 32'hBFD0_0000, 1, MLEN1, MSIZE1, 4'b0001);
        issue(32'hBFD0_0000, 4'h0, 32'h0, 1, MSIZE1, 1, 32'hFFD0_00EE);
        wait_done();
        chk_burst("uncached read", 32'hBFD0_0000, 0, MLEN1, MSIZE1, 4'h0);
        issue(32'h1008, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hA2);
        check("hit after uncached", 32'(dresp.data_ok), 32'h1);
        wait_done();
        check("hit after uncached bus idle", 32'(bus_q.size()), 32'h0);

        // reset on the second refill beat abandons the line
        issue(32'h2004, 4'h0, 32'h0, 0, MSIZE4, 0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(creq.valid && !creq.is_write && beat == 1 && cresp.ready) && n < 50);
        check("second refill beat reached", 32'(beat), 32'h1);
        resetn = 1'b0;
        #1;
        check("reset creq.valid", 32'(creq.valid), 32'h0);
        check("reset mid addr_ok", 32'(dresp.addr_ok), 32'h0);
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus_q.delete();
        issue(32'h2004, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_2004);
        wait_done();
        chk_burst("re-miss after reset", 32'h2000, 0, MLEN4, MSIZE4, 4'h0);

        // valid held through a miss: one accept per request
        a0 = accepts;
        issue(32'h3000, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_3000);
        issue(32'h3004, 4'h0, 32'h0, 0, MSIZE4, 1, 32'hC000_3004);
        wait_done();
        check("accept count", 32'(accepts - a0), 32'h2);
        chk_burst("back-to-back refill", 32'h3000, 0, MLEN4, MSIZE4, 4'h0);
        check("back-to-back single burst", 32'(bus_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
